mem_ctrl: RTL and testbench

//  Arbiter and byte sequencer for the single byte-wide synchronous RAM port.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM sequencer: reset level, access
// size encodings, FSM state encodings and the byte-count helper.
package mem_ctrl_pkg;

   localparam logic        RstEnable = 1'b1;

   localparam logic [1:0]  SIZE_B    = 2'b00;
   localparam logic [1:0]  SIZE_H    = 2'b01;
   localparam logic [1:0]  SIZE_W    = 2'b10;

   localparam logic [31:0] ZeroWord  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10
   } state_t;

   // Number of RAM byte cycles for an access size; the reserved code 11 is a word.
   function automatic logic [2:0] size_len(input logic [1:0] size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer for the single byte-wide synchronous RAM port.
// The MEM stage has priority over instruction fetch; each granted request is
// split into per-byte RAM cycles and read bytes are assembled little-endian.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din
);

   state_t            state, state_nxt;
   logic [2:0]        cnt;
   logic [2:0]        len;
   logic [2:0]        cnt_inc;
   logic [2:0]        cnt_dec;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic              owner_if;
   logic              if_done_q;
   logic              ls_done_q;
   logic              ls_go;
   logic              if_go;
   logic              rd_last;
   logic              rd_abort;
   logic              wr_last;

   // Byte idx of a word; out-of-range indices yield zero.
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [2:0] idx);
      case (idx)
         3'd0:    return word[7:0];
         3'd1:    return word[15:8];
         3'd2:    return word[23:16];
         3'd3:    return word[31:24];
         default: return 8'h00;
      endcase
   endfunction

   // Replace lane idx of a word with data; other lanes are kept.
   function automatic logic [31:0] lane_insert(input logic [31:0] word, input logic [2:0] idx,
                                               input logic [7:0] data);
      logic [31:0] r;
      r = word;
      case (idx)
         3'd0:    r[7:0]   = data;
         3'd1:    r[15:8]  = data;
         3'd2:    r[23:16] = data;
         3'd3:    r[31:24] = data;
         default: r = word;
      endcase
      return r;
   endfunction

   // cnt counts cycles since acceptance; read data trails the address by one cycle.
   assign cnt_inc = cnt + 3'd1;
   assign cnt_dec = cnt - 3'd1;

   // A flush arriving in the done cycle suppresses the fetch completion.
   assign if_done = if_done_q & ~if_flush;
   assign ls_done = ls_done_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst == RstEnable) state <= ST_IDLE;
      else                  state <= state_nxt;
   end

   // Arbitration, abort and end-of-access decisions
   always_comb begin
      state_nxt = state;
      ls_go     = 1'b0;
      if_go     = 1'b0;
      rd_last   = 1'b0;
      rd_abort  = 1'b0;
      wr_last   = 1'b0;
      case (state)
         ST_IDLE: begin
            // A port that is completing this cycle still shows its old request.
            ls_go = ls_req & ~ls_done_q;
            if_go = if_req & ~if_done_q & ~if_flush & ~ls_go;
            if (ls_go)      state_nxt = ls_we ? ST_WRITE : ST_READ;
            else if (if_go) state_nxt = ST_READ;
         end
         ST_READ: begin
            rd_abort = owner_if & if_flush;
            rd_last  = (cnt == len);
            if (rd_abort || rd_last) state_nxt = ST_IDLE;
         end
         ST_WRITE: begin
            wr_last = (cnt_inc == len);
            if (wr_last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latching, RAM port drive, byte capture and completion pulses
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt       <= 3'd0;
         len       <= 3'd0;
         base      <= '0;
         wdata_q   <= ZeroWord;
         rbuf      <= ZeroWord;
         owner_if  <= 1'b0;
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         mem_a     <= '0;
         mem_dout  <= 8'h00;
         mem_wr    <= 1'b0;
         if_inst   <= ZeroWord;
         ls_rdata  <= ZeroWord;
      end else begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         mem_wr    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ls_go) begin
                  base     <= ls_addr;
                  len      <= size_len(ls_size);
                  wdata_q  <= ls_wdata;
                  owner_if <= 1'b0;
                  cnt      <= 3'd0;
                  rbuf     <= ZeroWord;
                  mem_a    <= ls_addr;
                  if (ls_we) begin
                     mem_dout <= ls_wdata[7:0];
                     mem_wr   <= 1'b1;
                  end
               end else if (if_go) begin
                  base     <= if_addr;
                  len      <= 3'd4;
                  owner_if <= 1'b1;
                  cnt      <= 3'd0;
                  rbuf     <= ZeroWord;
                  mem_a    <= if_addr;
               end
            end
            ST_READ: begin
               if (!rd_abort) begin
                  cnt <= cnt_inc;
                  if (cnt != 3'd0) rbuf <= lane_insert(rbuf, cnt_dec, mem_din);
                  if (cnt_inc < len) mem_a <= base + ADDR_W'(cnt_inc);
                  if (rd_last) begin
                     if (owner_if) begin
                        if_inst   <= lane_insert(rbuf, cnt_dec, mem_din);
                        if_done_q <= 1'b1;
                     end else begin
                        ls_rdata  <= lane_insert(rbuf, cnt_dec, mem_din);
                        ls_done_q <= 1'b1;
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (wr_last) begin
                  ls_done_q <= 1'b1;
               end else begin
                  cnt      <= cnt_inc;
                  mem_a    <= base + ADDR_W'(cnt_inc);
                  mem_dout <= byte_sel(wdata_q, cnt_inc);
                  mem_wr   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random load/store/fetch traffic
// against a byte-array memory model and a shadow image of expected contents.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_done;
   logic [31:0] if_inst;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;

   logic        poke_en;
   logic [15:0] poke_addr;
   logic [7:0]  poke_data;

   bit [7:0]    ram    [0:65535];
   bit [7:0]    shadow [0:65535];

   int          checks;
   int          errors;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_inst(if_inst),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte RAM: read data one cycle after the address, write on the edge.
   always @(posedge clk) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr)  ram[mem_a[15:0]] <= mem_dout;
      if (poke_en) ram[poke_addr]   <= poke_data;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      poke_addr = a[15:0];
      poke_data = d;
      poke_en   = 1'b1;
      shadow[a[15:0]] = d;
      @(posedge clk); #1;
      poke_en   = 1'b0;
   endtask

   function automatic int model_len(input logic [1:0] size);
      if (size == 2'b00) return 1;
      if (size == 2'b01) return 2;
      return 4;
   endfunction

   // Little-endian assembly of n bytes from the shadow image, upper bytes zero.
   function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
      logic [31:0] w;
      logic [31:0] aj;
      w = 32'h0;
      for (int j = 0; j < n; j++) begin
         aj = a + 32'(j);
         w[8*j +: 8] = shadow[aj[15:0]];
      end
      return w;
   endfunction

   // One complete access with cycle-by-cycle checks of the RAM port and done timing.
   task automatic run_xfer(input bit is_if, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input string tag, output logic [31:0] res);
      int          n;
      int          d;
      int          k;
      bit          seen;
      bit          done_now;
      bit          is_st;
      logic [31:0] expw;
      logic [31:0] aj;
      is_st = !is_if && we;
      n     = is_if ? 4 : model_len(size);
      d     = is_st ? n : n + 1;
      expw  = model_word(addr, n);
      if (is_st) begin
         for (int j = 0; j < n; j++) begin
            aj = addr + 32'(j);
            shadow[aj[15:0]] = wdata[8*j +: 8];
         end
      end
      res  = 32'h0;
      seen = 1'b0;
      @(posedge clk); #1;
      if (is_if) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         ls_req   = 1'b1;
         ls_we    = we;
         ls_size  = size;
         ls_addr  = addr;
         ls_wdata = wdata;
      end
      for (int t = 0; t <= d + 1 && !seen; t++) begin
         @(negedge clk);
         k = t - 1;
         done_now = is_if ? if_done : ls_done;
         chk({tag, "/mem_wr"}, 32'(mem_wr), 32'(is_st && k >= 0 && k < n));
         if (k >= 0 && k < n) begin
            chk({tag, "/mem_a"}, mem_a, addr + 32'(k));
            if (is_st) chk({tag, "/mem_dout"}, 32'(mem_dout), 32'(wdata[8*k +: 8]));
         end
         if (done_now || k == d) begin
            chk({tag, "/done_cycle"}, done_now ? 32'(k) : 32'hFFFF_FFFF, 32'(d));
            res  = is_if ? if_inst : ls_rdata;
            seen = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!is_st) chk({tag, "/data"}, res, expw);
      if (is_if) if_req = 1'b0;
      else       ls_req = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] ra;
      logic [31:0] rw;
      logic [1:0]  rs;
      int          p;
      bit          seen;
      bit          ls_seen;

      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = 32'h0;
      if_flush = 1'b0;
      ls_req   = 1'b0;
      ls_we    = 1'b0;
      ls_size  = 2'b00;
      ls_addr  = 32'h0;
      ls_wdata = 32'h0;
      poke_en  = 1'b0;
      poke_addr = 16'h0;
      poke_data = 8'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst/mem_wr",   32'(mem_wr),   32'h0);
      chk("rst/if_done",  32'(if_done),  32'h0);
      chk("rst/ls_done",  32'(ls_done),  32'h0);
      chk("rst/mem_a",    mem_a,         32'h0);
      chk("rst/mem_dout", 32'(mem_dout), 32'h0);
      chk("rst/if_inst",  if_inst,       32'h0);
      chk("rst/ls_rdata", ls_rdata,      32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Preload: fixed images for directed cases, random bytes for the random region
      poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
      poke(32'h7, 8'h80);   poke(32'h8, 8'hFF);
      poke(32'h200, 8'h11); poke(32'h201, 8'h22); poke(32'h202, 8'h33); poke(32'h203, 8'h44);
      poke(32'h300, 8'h93); poke(32'h301, 8'h05); poke(32'h302, 8'hA0); poke(32'h303, 8'h00);
      poke(32'hFFFF_FFFF, 8'h5A); poke(32'h0, 8'hC3); poke(32'h1, 8'h7E); poke(32'h2, 8'h01);
      poke(32'h4000, 8'hAA); poke(32'h4001, 8'hBB); poke(32'h4002, 8'hCC); poke(32'h4003, 8'hDD);
      for (int i = 0; i < 36; i++) poke(32'h3000 + 32'(i), 8'($urandom));

      // Fetch of a NOP word
      run_xfer(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, "fetch", r);
      chk("fetch/inst_const", r, 32'h0000_0013);

      // Unaligned word store, then read back
      run_xfer(1'b0, 1'b1, 2'b10, 32'h2002, 32'hDEAD_BEEF, "store_w", r);
      run_xfer(1'b0, 1'b0, 2'b10, 32'h2002, 32'h0, "store_w_rb", r);
      chk("store_w_rb/const", r, 32'hDEAD_BEEF);

      // Half load, zero-extended
      run_xfer(1'b0, 1'b0, 2'b01, 32'h7, 32'h0, "load_h", r);
      chk("load_h/const", r, 32'h0000_FF80);

      // Word load wrapping past the top of the address space
      run_xfer(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0, "wrap", r);
      chk("wrap/const", r, 32'h017E_C35A);

      // Simultaneous requests: load first, fetch granted in the load's done cycle
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h7;
      if_req = 1'b1; if_addr = 32'h100;
      seen = 1'b0; ls_seen = 1'b0;
      for (int t = 0; t <= 14 && !seen; t++) begin
         @(negedge clk);
         chk("arb/mem_wr", 32'(mem_wr), 32'h0);
         if (t == 5) chk("arb/fetch_addr", mem_a, 32'h100);
         if (ls_done) begin
            chk("arb/ls_cycle", 32'(t), 32'd4);
            chk("arb/ls_data", ls_rdata, model_word(32'h7, 2));
            ls_seen = 1'b1;
         end
         if (if_done) begin
            chk("arb/if_cycle", 32'(t), 32'd10);
            chk("arb/if_inst", if_inst, model_word(32'h100, 4));
            seen = 1'b1;
         end
         @(posedge clk); #1;
         if (ls_seen) ls_req = 1'b0;
      end
      chk("arb/ls_seen", 32'(ls_seen), 32'h1);
      chk("arb/if_seen", 32'(seen), 32'h1);
      if_req = 1'b0; ls_req = 1'b0;

      // Flush in fetch cycle 2, redirect to a branch target
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h200;
      seen = 1'b0;
      for (int t = 0; t <= 14 && !seen; t++) begin
         if (t == 3) begin if_flush = 1'b1; if_addr = 32'h300; end
         if (t == 4) if_flush = 1'b0;
         @(negedge clk);
         chk("flush/mem_wr", 32'(mem_wr), 32'h0);
         if (t == 5) chk("flush/new_addr", mem_a, 32'h300);
         if (if_done) begin
            chk("flush/done_cycle", 32'(t), 32'd10);
            chk("flush/inst", if_inst, model_word(32'h300, 4));
            seen = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("flush/seen", 32'(seen), 32'h1);
      if_req = 1'b0;

      // Flush coinciding with the done cycle gates if_done and blocks a re-grant
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100;
      for (int t = 0; t <= 9; t++) begin
         if (t == 6) if_flush = 1'b1;
         if (t == 7) begin if_flush = 1'b0; if_req = 1'b0; end
         @(negedge clk);
         chk("gate/if_done", 32'(if_done), 32'h0);
         if (t == 7) chk("gate/no_accept", mem_a, 32'h103);
         @(posedge clk); #1;
      end

      // Reset in the middle of a word store
      @(posedge clk); #1;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h4000; ls_wdata = 32'h1122_3344;
      for (int t = 0; t <= 8; t++) begin
         if (t == 2) rst = 1'b1;
         if (t == 3) begin rst = 1'b0; ls_req = 1'b0; end
         @(negedge clk);
         if (t == 3) begin
            chk("rst_mid/mem_a",    mem_a,         32'h0);
            chk("rst_mid/mem_dout", 32'(mem_dout), 32'h0);
         end
         if (t >= 3) begin
            chk("rst_mid/mem_wr",  32'(mem_wr),  32'h0);
            chk("rst_mid/ls_done", 32'(ls_done), 32'h0);
         end
         @(posedge clk); #1;
      end
      shadow[16'h4000] = 8'h44;
      shadow[16'h4001] = 8'h33;
      run_xfer(1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, "rst_mid_rb", r);
      chk("rst_mid_rb/const", r, 32'hDDCC_3344);

      // Random mixed traffic against the shadow image
      for (int it = 0; it < 40; it++) begin
         p  = int'($urandom_range(0, 2));
         rs = 2'($urandom_range(0, 3));
         ra = 32'h3000 + 32'($urandom_range(0, 31));
         rw = $urandom;
         run_xfer(p == 0, p == 2, rs, ra, rw, "rand", r);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
